// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and BCD limits for the time-of-day controller.
package clock_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1, SET_HR = 2'd2, SET_MIN = 2'd3} state_t;
    localparam logic [3:0] HOUR_MAX_T = 4'd2;
    localparam logic [3:0] HOUR_MAX_U = 4'd3;
    localparam logic [3:0] MIN_MAX_T = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [7:0] LOAD_SEC_ZERO = 8'h00;
endpackage

// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: bus between the mode controller and the BCD time counter.
interface clock_ctrl_if;
    logic [3:0] cur_hour1, cur_hour2, cur_min1, cur_min2;
    logic       count_en, load;
    logic [3:0] load_hour1, load_hour2, load_min1, load_min2;
    logic [7:0] load_sec;
    modport master (
        input  cur_hour1, cur_hour2, cur_min1, cur_min2,
        output count_en, load, load_hour1, load_hour2, load_min1, load_min2, load_sec
    );
    modport slave (
        output cur_hour1, cur_hour2, cur_min1, cur_min2,
        input  count_en, load, load_hour1, load_hour2, load_min1, load_min2, load_sec
    );
endinterface

// File: rtl/clock_ctrl_debounce.sv
// btn_debounce: synchronizes an active-low button and emits one pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic s1, s2, level, diff, done;
    logic [DB_W-1:0] cnt;
    assign diff = s2 != level;
    assign done = diff && cnt == DB_W'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            level <= 1'b1;
            cnt <= '0;
            press <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            cnt <= (diff && !done) ? cnt + 1'b1 : '0;
            if (done) level <= s2;
            // level still high while accepting a change means a 1->0 edge
            press <= done && level;
        end
    end
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: RUN/PAUSE/SET_HR/SET_MIN controller gating the 1 Hz tick and loading edited time.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_in,
    input  logic         mode_btn,
    input  logic         pause_btn,
    input  logic         inc_btn,
    clock_ctrl_if.master bus,
    output logic [1:0]   mode,
    output logic         blank_hr,
    output logic         blank_min
);
    state_t state, state_nx;
    logic p_mode, p_pause, p_inc, ev_mode, ev_pause, ev_inc;
    logic [3:0] h1, h2, m1, m2, h1_nx, h2_nx, m1_nx, m2_nx;
    logic blink, blink_nx, load_q, load_nx, count_q, count_nx, bhr_q, bmin_q;
    logic in_set, hr_ok, min_ok, hr_wrap, min_wrap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_mode (.clk(clk), .reset(reset), .btn(mode_btn), .press(p_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_pause (.clk(clk), .reset(reset), .btn(pause_btn), .press(p_pause));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_inc (.clk(clk), .reset(reset), .btn(inc_btn), .press(p_inc));

    assign ev_mode = p_mode;
    assign ev_pause = p_pause && !p_mode;
    assign ev_inc = p_inc && !p_mode && !p_pause;
    assign in_set = state == SET_HR || state == SET_MIN;
    assign hr_ok = (bus.cur_hour1 < HOUR_MAX_T && bus.cur_hour2 <= DIGIT_MAX) ||
                   (bus.cur_hour1 == HOUR_MAX_T && bus.cur_hour2 <= HOUR_MAX_U);
    assign min_ok = bus.cur_min1 <= MIN_MAX_T && bus.cur_min2 <= DIGIT_MAX;
    assign hr_wrap = h1 == HOUR_MAX_T && h2 == HOUR_MAX_U;
    assign min_wrap = m1 == MIN_MAX_T && m2 == DIGIT_MAX;

    always_comb begin
        state_nx = state;
        {h1_nx, h2_nx, m1_nx, m2_nx} = {h1, h2, m1, m2};
        blink_nx = in_set && (blink ^ tick_in);
        load_nx = 1'b0;
        case (state)
            RUN, PAUSE: begin
                if (ev_mode) begin
                    state_nx = SET_HR;
                    h1_nx = hr_ok ? bus.cur_hour1 : 4'd0;
                    h2_nx = hr_ok ? bus.cur_hour2 : 4'd0;
                    m1_nx = min_ok ? bus.cur_min1 : 4'd0;
                    m2_nx = min_ok ? bus.cur_min2 : 4'd0;
                end else if (ev_pause) state_nx = (state == RUN) ? PAUSE : RUN;
            end
            SET_HR: begin
                if (ev_mode) begin
                    state_nx = SET_MIN;
                    blink_nx = 1'b0;
                end else if (ev_inc) begin
                    h1_nx = hr_wrap ? 4'd0 : (h2 == DIGIT_MAX ? h1 + 4'd1 : h1);
                    h2_nx = (hr_wrap || h2 == DIGIT_MAX) ? 4'd0 : h2 + 4'd1;
                end
            end
            default: begin
                if (ev_mode) begin
                    state_nx = RUN;
                    load_nx = 1'b1;
                    blink_nx = 1'b0;
                end else if (ev_inc) begin
                    m1_nx = min_wrap ? 4'd0 : (m2 == DIGIT_MAX ? m1 + 4'd1 : m1);
                    m2_nx = (min_wrap || m2 == DIGIT_MAX) ? 4'd0 : m2 + 4'd1;
                end
            end
        endcase
        // a tick landing on the load cycle would collide with the fresh load
        count_nx = tick_in && state == RUN && !load_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            {h1, h2, m1, m2} <= '0;
            blink <= 1'b0;
            load_q <= 1'b0;
            count_q <= 1'b0;
            bhr_q <= 1'b0;
            bmin_q <= 1'b0;
        end else begin
            state <= state_nx;
            {h1, h2, m1, m2} <= {h1_nx, h2_nx, m1_nx, m2_nx};
            blink <= blink_nx;
            load_q <= load_nx;
            count_q <= count_nx;
            bhr_q <= blink_nx && state_nx == SET_HR;
            bmin_q <= blink_nx && state_nx == SET_MIN;
        end
    end

    assign mode = state;
    assign blank_hr = bhr_q;
    assign blank_min = bmin_q;
    assign bus.count_en = count_q;
    assign bus.load = load_q;
    assign bus.load_hour1 = h1;
    assign bus.load_hour2 = h2;
    assign bus.load_min1 = m1;
    assign bus.load_min2 = m2;
    assign bus.load_sec = LOAD_SEC_ZERO;
endmodule
